// File: rtl/calc_entry_fsm.sv
// Key-entry controller: assembles two decimal operands and an operator from
// decoded key events and hands them to the ALU over a valid/ready handshake.
module calc_entry_fsm #(
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned WIDTH      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             alu_ready,
  output logic             alu_start,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [1:0]       op_sel,
  output logic [WIDTH-1:0] entry_val,
  output logic [1:0]       digit_cnt
);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    ISSUE   = 2'd2
  } state_e;

  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [1:0]       op_sel_q, op_sel_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] entry_q, entry_d;

  logic             is_digit, is_op, is_enter, is_clear;
  logic [3:0]       op_off;

  // x*10 + d using shifts; truncation to WIDTH is harmless for legal parameters
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] x,
                                                input logic [3:0] d);
    shift_in = (x << 3) + (x << 1) + WIDTH'(d);
  endfunction

  always_comb begin
    is_digit = key_valid && (key_code <= 4'd9);
    is_op    = key_valid && (key_code >= 4'd10) && (key_code <= 4'd13);
    is_enter = key_valid && (key_code == 4'd14);
    is_clear = key_valid && (key_code == 4'd15);
    op_off   = key_code - 4'd10;
  end

  // Next-state and next-output computation
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_sel_d = op_sel_q;
    cnt_d    = cnt_q;
    start_d  = start_q;
    entry_d  = entry_q;

    case (state_q)
      ENTER_A: begin
        if (is_digit) begin
          if (cnt_q == 2'd0) begin
            op_a_d = WIDTH'(key_code);
            cnt_d  = 2'd1;
          end else if (cnt_q < MAX_CNT) begin
            op_a_d = shift_in(op_a_q, key_code);
            cnt_d  = cnt_q + 2'd1;
          end
        end else if (is_op) begin
          op_sel_d = op_off[1:0];
          op_b_d   = '0;
          cnt_d    = 2'd0;
          state_d  = ENTER_B;
        end
      end
      ENTER_B: begin
        if (is_digit) begin
          if (cnt_q == 2'd0) begin
            op_b_d = WIDTH'(key_code);
            cnt_d  = 2'd1;
          end else if (cnt_q < MAX_CNT) begin
            op_b_d = shift_in(op_b_q, key_code);
            cnt_d  = cnt_q + 2'd1;
          end
        end else if (is_op) begin
          if (cnt_q == 2'd0) op_sel_d = op_off[1:0];
        end else if (is_enter) begin
          if (cnt_q != 2'd0) begin
            state_d = ISSUE;
            start_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        // Operands stay put after the transfer; the next digit starts fresh
        if (start_q && alu_ready) begin
          state_d = ENTER_A;
          start_d = 1'b0;
          cnt_d   = 2'd0;
        end
      end
      default: begin
        state_d = ENTER_A;
        start_d = 1'b0;
      end
    endcase

    if (is_clear) begin
      state_d  = ENTER_A;
      op_a_d   = '0;
      op_b_d   = '0;
      op_sel_d = 2'd0;
      cnt_d    = 2'd0;
      start_d  = 1'b0;
    end

    // Display shows A until the first B digit lands
    case (state_d)
      ENTER_A: entry_d = op_a_d;
      ENTER_B: entry_d = (cnt_d != 2'd0) ? op_b_d : op_a_d;
      ISSUE:   entry_d = op_b_d;
      default: entry_d = op_a_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ENTER_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sel_q <= 2'd0;
      cnt_q    <= 2'd0;
      start_q  <= 1'b0;
      entry_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_sel_q <= op_sel_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      entry_q  <= entry_d;
    end
  end

  assign alu_start = start_q;
  assign operand_a = op_a_q;
  assign operand_b = op_b_q;
  assign op_sel    = op_sel_q;
  assign entry_val = entry_q;
  assign digit_cnt = cnt_q;

endmodule
